// File: rtl/bitxor_pkg.sv
// Shared constants and types for the range-XOR query controller and its endpoint register.
package bitxor_pkg;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_SETL = 2'b01;
  localparam logic [1:0] INST_SETR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/endpreg.sv
// Endpoint register pair: SETL captures ztonxor into ql, SETR into qr; ltorxor is their XOR.
module endpreg
  import bitxor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] inst,
  input  logic       ztonxor,
  output logic       ltorxor
);

  logic ql;
  logic qr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ql <= 1'b0;
      qr <= 1'b0;
    end else begin
      if (inst == INST_SETL) ql <= ztonxor;
      if (inst == INST_SETR) qr <= ztonxor;
    end
  end

  assign ltorxor = ql ^ qr;

endmodule

// File: rtl/bitxor_query_ctrl.sv
// Range-XOR query sequencer: scans a prefix XOR over data[0..r], latching P(l-1) and P(r)
// into the endpoint register so the result is their XOR.
module bitxor_query_ctrl
  import bitxor_pkg::*;
#(
  parameter  int N    = 16,
  localparam int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            q_valid,
  output logic            q_ready,
  input  logic [N-1:0]    q_data,
  input  logic [IDXW-1:0] q_l,
  input  logic [IDXW-1:0] q_r,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_bit,
  output logic            res_err,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and its payload are held stable until that edge.

  state_t          state_q, state_d;
  logic [N-1:0]    data_q;
  logic [IDXW-1:0] l_q, r_q, idx_q;
  logic            err_q;
  logic            acc_q;
  logic            nxt;
  logic [IDXW:0]   idx_plus1;
  logic [1:0]      inst;
  logic            ztonxor;
  logic            ltorxor;

  assign nxt = acc_q ^ data_q[idx_q];
  // Widened so idx+1 never wraps back onto a small l.
  assign idx_plus1 = {1'b0, idx_q} + {{IDXW{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    inst    = INST_NOP;
    ztonxor = 1'b0;
    case (state_q)
      IDLE: begin
        if (q_valid) state_d = START;
      end
      START: begin
        if (err_q) begin
          state_d = DONE;
        end else begin
          inst    = INST_SETL;
          state_d = SCAN;
        end
      end
      SCAN: begin
        ztonxor = nxt;
        if (idx_q == r_q) begin
          inst    = INST_SETR;
          state_d = DONE;
        end else if (idx_plus1 == {1'b0, l_q}) begin
          inst = INST_SETL;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      l_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      acc_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (q_valid) begin
            data_q <= q_data;
            l_q    <= q_l;
            r_q    <= q_r;
            err_q  <= (q_l > q_r);
          end
        end
        START: begin
          acc_q <= 1'b0;
          idx_q <= '0;
        end
        SCAN: begin
          acc_q <= nxt;
          if (idx_q != r_q) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  endpreg u_endpreg (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst),
    .ztonxor (ztonxor),
    .ltorxor (ltorxor)
  );

  assign q_ready   = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_err   = (state_q == DONE) & err_q;
  // ENDPREG holds stale values on the error path, so the result is masked.
  assign res_bit   = (state_q == DONE) & ~err_q & ltorxor;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bitxor_query_ctrl.sv
// Self-checking bench for bitxor_query_ctrl with a scoreboard of {err, bit} results.
module tb_bitxor_query_ctrl;
  import bitxor_pkg::*;

  localparam int N    = 16;
  localparam int IDXW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            q_valid;
  logic            q_ready;
  logic [N-1:0]    q_data;
  logic [IDXW-1:0] q_l, q_r;
  logic            res_valid;
  logic            res_ready;
  logic            res_bit;
  logic            res_err;
  logic            busy;
  logic [1:0]      state_dbg;

  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int lat_exp;
  logic err_exp;

  always #5 clk = ~clk;

  bitxor_query_ctrl #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_data    (q_data),
    .q_l       (q_l),
    .q_r       (q_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_bit   (res_bit),
    .res_err   (res_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic model_xor(input logic [N-1:0] d, input int l, input int r);
    logic x = 1'b0;
    for (int i = l; i <= r; i++) x ^= d[i];
    return x;
  endfunction

  // Offer a query at the next falling edge; it is accepted on the following rising edge.
  task automatic send(input logic [N-1:0] d, input int l, input int r, input logic [N-1:0] post_d);
    @(negedge clk);
    check("q_ready_before_accept", q_ready, 1);
    q_valid = 1'b1;
    q_data  = d;
    q_l     = IDXW'(l);
    q_r     = IDXW'(r);
    @(posedge clk);
    #1;
    q_valid = 1'b0;
    q_data  = post_d;
    err_exp = (l > r);
    lat_exp = (l > r) ? 1 : r + 2;
    exp_q.push_back((l > r) ? 2'b10 : {1'b0, model_xor(d, l, r)});
  endtask

  task automatic wait_result();
    int n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (err_exp) check("err_inst_nop", dut.inst, INST_NOP);
      if (res_valid) break;
      n++;
    end
    if (n >= 200) check("result_timeout", 0, 1);
    else check("latency", n, lat_exp);
  endtask

  // Hold res_ready low for 'hold' cycles, then complete the handshake.
  task automatic take_result(input int hold);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("hold_res_valid", res_valid, 1);
      check("hold_res_bit", res_bit, e[0]);
      check("hold_q_ready", q_ready, 0);
      @(negedge clk);
    end
    check("res_valid", res_valid, 1);
    check("res_bit", res_bit, e[0]);
    check("res_err", res_err, e[1]);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check("post_hs_q_ready", q_ready, 1);
    check("post_hs_res_valid", res_valid, 0);
  endtask

  task automatic query(input logic [N-1:0] d, input int l, input int r,
                       input logic [N-1:0] post_d, input int hold);
    send(d, l, r, post_d);
    wait_result();
    take_result(hold);
  endtask

  int tl[4] = '{0, 2, 6, 0};
  int tr[4] = '{0, 7, 8, 15};

  initial begin
    reset     = 1'b1;
    q_valid   = 1'b0;
    q_data    = '0;
    q_l       = '0;
    q_r       = '0;
    res_ready = 1'b0;
    err_exp   = 1'b0;
    lat_exp   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_q_ready", q_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_bit", res_bit, 0);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, IDLE);
    check("rst_inst", dut.inst, INST_NOP);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) query(16'hA5C3, tl[i], tr[i], 16'hA5C3, 0);

    query(16'hA5C3, 5, 3, 16'hA5C3, 0);
    query(16'hA5C3, 6, 8, 16'hA5C3, 5);
    query(16'hA5C3, 3, 3, 16'h5A3C, 0);

    // Reset in the middle of a scan.
    send(16'hA5C3, 2, 10, 16'hA5C3);
    repeat (5) @(posedge clk);
    #1;
    check("mid_scan_state", state_dbg, SCAN);
    check("mid_scan_idx", dut.idx_q, 4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_q_ready", q_ready, 1);
    check("abort_res_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    query(16'hA5C3, 0, 1, 16'hA5C3, 0);

    // Input changes after accept must not reach the result.
    query(16'hA5C3, 0, 15, 16'h0000, 0);
    query(16'h0001, 0, 15, 16'hFFFF, 0);

    for (int k = 0; k < 10; k++) begin
      logic [N-1:0] d;
      int l, r;
      d = N'($urandom);
      l = $urandom_range(0, N - 1);
      r = $urandom_range(0, N - 1);
      query(d, l, r, N'($urandom), $urandom_range(0, 3));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
